// File: rtl/mcyc_ctrl.sv
// Multi-cycle control FSM for a MIPS subset: latches the fetched word, decodes it and sequences datapath strobes.
// Optional ILLEGAL_TRAP_EN: an undecodable instruction halts the FSM until reset instead of running as a nop.
module mcyc_ctrl #(
  parameter int         MEM_WAIT = 1,
  parameter logic [4:0] RA_REG   = 5'd31
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] inst_code,
  input  logic        zero,
  output logic        pc_we,
  output logic [1:0]  pc_s,
  output logic [15:0] imm_data,
  output logic [25:0] address,
  output logic [4:0]  rs,
  output logic [4:0]  rt,
  output logic [4:0]  wa,
  output logic        rf_we,
  output logic [1:0]  wd_sel,
  output logic [3:0]  alu_op,
  output logic        alu_src_b,
  output logic        imm_sext,
  output logic        mem_we,
  output logic        illegal
);

  // state    | meaning
  // S_FETCH  | ir captures inst_code at the end of this cycle
  // S_DECODE | decode settles, no strobes
  // S_EXEC   | branches/jumps/nops finish here; loads/stores go to S_MEM, writers to S_WB
  // S_MEM    | data RAM access, MEM_WAIT cycles
  // S_WB     | register-file write plus PC update
  // S_HALT   | trapped on an undecodable instruction, waits for reset
  typedef enum logic [2:0] {S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_HALT} state_t;

  localparam int CW = (MEM_WAIT > 1) ? $clog2(MEM_WAIT) : 1;

  state_t        state, state_nxt;
  logic [31:0]   ir;
  logic [CW-1:0] cnt;
  logic          last_mem, set_ill;
  logic [5:0]    op, funct;
  logic          dec_ok, is_rtype, is_br, is_beq, is_j, is_jr, is_jal, is_lw, is_sw;

  assign op       = ir[31:26];
  assign funct    = ir[5:0];
  assign rs       = ir[25:21];
  assign rt       = ir[20:16];
  assign imm_data = ir[15:0];
  assign address  = ir[25:0];
  assign last_mem = (cnt == CW'(MEM_WAIT - 1));
  assign wa       = is_jal ? RA_REG : (is_rtype ? ir[15:11] : ir[20:16]);

  always_comb begin
    dec_ok    = 1'b1;
    is_rtype  = 1'b0;
    is_br     = 1'b0;
    is_beq    = 1'b0;
    is_j      = 1'b0;
    is_jr     = 1'b0;
    is_jal    = 1'b0;
    is_lw     = 1'b0;
    is_sw     = 1'b0;
    alu_op    = 4'd0;
    alu_src_b = 1'b0;
    imm_sext  = 1'b0;
    wd_sel    = 2'b00;
    case (op)
      6'h00: begin
        is_rtype = 1'b1;
        case (funct)
          6'h20: alu_op = 4'd0;
          6'h22: alu_op = 4'd1;
          6'h24: alu_op = 4'd2;
          6'h25: alu_op = 4'd3;
          6'h26: alu_op = 4'd4;
          6'h27: alu_op = 4'd5;
          6'h2A: alu_op = 4'd6;
          6'h00: alu_op = 4'd7;
          6'h02: alu_op = 4'd8;
          6'h08: is_jr  = 1'b1;
          default: dec_ok = 1'b0;
        endcase
      end
      6'h08: begin alu_src_b = 1'b1; imm_sext = 1'b1; end
      6'h0C: begin alu_op = 4'd2; alu_src_b = 1'b1; end
      6'h0D: begin alu_op = 4'd3; alu_src_b = 1'b1; end
      6'h0E: begin alu_op = 4'd4; alu_src_b = 1'b1; end
      6'h0F: begin wd_sel = 2'b11; alu_src_b = 1'b1; end
      6'h23: begin is_lw = 1'b1; alu_src_b = 1'b1; imm_sext = 1'b1; wd_sel = 2'b01; end
      6'h2B: begin is_sw = 1'b1; alu_src_b = 1'b1; imm_sext = 1'b1; end
      6'h04: begin is_br = 1'b1; is_beq = 1'b1; alu_op = 4'd1; imm_sext = 1'b1; end
      6'h05: begin is_br = 1'b1; alu_op = 4'd1; imm_sext = 1'b1; end
      6'h02: is_j = 1'b1;
      6'h03: begin is_jal = 1'b1; wd_sel = 2'b10; end
      default: dec_ok = 1'b0;
    endcase
  end

  always_comb begin
    state_nxt = state;
    pc_we     = 1'b0;
    pc_s      = 2'b00;
    rf_we     = 1'b0;
    mem_we    = 1'b0;
    set_ill   = 1'b0;
    case (state)
      S_FETCH:  state_nxt = S_DECODE;
      S_DECODE: state_nxt = S_EXEC;
      S_EXEC: begin
        if (!dec_ok) begin
          set_ill = 1'b1;
`ifdef ILLEGAL_TRAP_EN
          state_nxt = S_HALT;
`else
          pc_we     = 1'b1;
          state_nxt = S_FETCH;
`endif
        end else if (is_br) begin
          pc_we     = 1'b1;
          pc_s      = (is_beq == zero) ? 2'b10 : 2'b00;
          state_nxt = S_FETCH;
        end else if (is_j || is_jr) begin
          pc_we     = 1'b1;
          pc_s      = is_j ? 2'b11 : 2'b01;
          state_nxt = S_FETCH;
        end else if (is_lw || is_sw) begin
          state_nxt = S_MEM;
        end else begin
          state_nxt = S_WB;
        end
      end
      S_MEM: begin
        if (last_mem) begin
          if (is_sw) begin
            mem_we    = 1'b1;
            pc_we     = 1'b1;
            state_nxt = S_FETCH;
          end else begin
            state_nxt = S_WB;
          end
        end
      end
      S_WB: begin
        rf_we     = (wa != 5'd0);
        pc_we     = 1'b1;
        pc_s      = is_jal ? 2'b11 : 2'b00;
        state_nxt = S_FETCH;
      end
      S_HALT:  state_nxt = S_HALT;
      default: state_nxt = S_FETCH;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= S_FETCH;
      ir      <= 32'h0;
      cnt     <= '0;
      illegal <= 1'b0;
    end else begin
      state <= state_nxt;
      if (state == S_FETCH) ir <= inst_code;
      // counter restarts whenever EXEC hands over to MEM
      if (state == S_EXEC) cnt <= '0;
      else if (state == S_MEM && !last_mem) cnt <= cnt + 1'b1;
      if (set_ill) illegal <= 1'b1;
    end
  end

endmodule

// File: tb/tb_mcyc_ctrl.sv
// Randomized bench for mcyc_ctrl: an instruction-level model predicts per-cycle strobes and decoded fields.
`timescale 1ns/1ps
module tb_mcyc_ctrl;
  localparam int MW = 3;
`ifdef ILLEGAL_TRAP_EN
  localparam bit TRAP = 1'b1;
`else
  localparam bit TRAP = 1'b0;
`endif
  localparam int K_ALU = 0, K_LW = 1, K_SW = 2, K_BR = 3, K_J = 4, K_JR = 5, K_JAL = 6, K_BAD = 7;

  typedef struct {
    int         kind;
    bit         rtype;
    bit         beq;
    bit         chk_alu;
    bit         chk_sext;
    logic [3:0] alu;
    bit         src_b;
    bit         sext;
    logic [1:0] wd;
  } info_t;

  logic        clk = 1'b0, rst = 1'b0, zero = 1'b0;
  logic [31:0] inst_code = 32'h0;
  logic        pc_we, rf_we, alu_src_b, imm_sext, mem_we, illegal;
  logic [1:0]  pc_s, wd_sel;
  logic [15:0] imm_data;
  logic [25:0] address;
  logic [4:0]  rs, rt, wa;
  logic [3:0]  alu_op;

  mcyc_ctrl #(.MEM_WAIT(MW), .RA_REG(5'd31)) dut (
    .clk(clk), .rst(rst), .inst_code(inst_code), .zero(zero),
    .pc_we(pc_we), .pc_s(pc_s), .imm_data(imm_data), .address(address),
    .rs(rs), .rt(rt), .wa(wa), .rf_we(rf_we), .wd_sel(wd_sel), .alu_op(alu_op),
    .alu_src_b(alu_src_b), .imm_sext(imm_sext), .mem_we(mem_we), .illegal(illegal)
  );

  always #5 clk = ~clk;

  int          vec_cnt = 0, err_cnt = 0;
  logic [31:0] prev_ir = 32'h0;
  bit          exp_ill = 1'b0;
  int          first_pcwe_k, first_mem_k;
  logic [4:0]  cap_wa;
  logic        cap_rf;
  logic [1:0]  cap_wd, cap_pcs;
  logic [3:0]  cap_alu;
  logic [15:0] cap_imm;
  logic [25:0] cap_addr;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vec_cnt++;
    if (act !== exp) begin
      err_cnt++;
      $display("FAIL %s at %0t: got %0h, expected %0h", nm, $time, act, exp);
    end
  endtask

  function automatic info_t decode(input logic [31:0] i);
    info_t d;
    d.kind = K_BAD; d.rtype = 0; d.beq = 0; d.chk_alu = 0; d.chk_sext = 0;
    d.alu = 4'd0; d.src_b = 0; d.sext = 0; d.wd = 2'b00;
    case (i[31:26])
      6'h00: begin
        d.rtype = 1; d.kind = K_ALU; d.chk_alu = 1;
        case (i[5:0])
          6'h20: d.alu = 4'd0;
          6'h22: d.alu = 4'd1;
          6'h24: d.alu = 4'd2;
          6'h25: d.alu = 4'd3;
          6'h26: d.alu = 4'd4;
          6'h27: d.alu = 4'd5;
          6'h2A: d.alu = 4'd6;
          6'h00: d.alu = 4'd7;
          6'h02: d.alu = 4'd8;
          6'h08: begin d.kind = K_JR; d.chk_alu = 0; end
          default: begin d.kind = K_BAD; d.chk_alu = 0; end
        endcase
      end
      6'h08: begin d.kind = K_ALU; d.chk_alu = 1; d.chk_sext = 1; d.alu = 4'd0; d.src_b = 1; d.sext = 1; end
      6'h0C: begin d.kind = K_ALU; d.chk_alu = 1; d.chk_sext = 1; d.alu = 4'd2; d.src_b = 1; end
      6'h0D: begin d.kind = K_ALU; d.chk_alu = 1; d.chk_sext = 1; d.alu = 4'd3; d.src_b = 1; end
      6'h0E: begin d.kind = K_ALU; d.chk_alu = 1; d.chk_sext = 1; d.alu = 4'd4; d.src_b = 1; end
      6'h0F: begin d.kind = K_ALU; d.wd = 2'b11; end
      6'h23: begin d.kind = K_LW; d.chk_alu = 1; d.chk_sext = 1; d.src_b = 1; d.sext = 1; d.wd = 2'b01; end
      6'h2B: begin d.kind = K_SW; d.chk_alu = 1; d.chk_sext = 1; d.src_b = 1; d.sext = 1; end
      6'h04: begin d.kind = K_BR; d.beq = 1; d.chk_alu = 1; d.chk_sext = 1; d.alu = 4'd1; d.sext = 1; end
      6'h05: begin d.kind = K_BR; d.chk_alu = 1; d.chk_sext = 1; d.alu = 4'd1; d.sext = 1; end
      6'h02: d.kind = K_J;
      6'h03: begin d.kind = K_JAL; d.wd = 2'b10; end
      default: d.kind = K_BAD;
    endcase
    return d;
  endfunction

  function automatic int ins_len(input info_t d);
    case (d.kind)
      K_ALU, K_JAL: return 4;
      K_LW:         return 4 + MW;
      K_SW:         return 3 + MW;
      default:      return 3;
    endcase
  endfunction

  function automatic logic [31:0] rand_ins(input bit allow_bad);
    logic [31:0] r;
    logic [5:0]  fn, op;
    int          sel;
    r = $urandom();
    sel = $urandom_range(0, allow_bad ? 21 : 19);
    fn = 6'h00; op = 6'h00;
    case (sel)
      0: fn = 6'h20;  1: fn = 6'h22;  2: fn = 6'h24;  3: fn = 6'h25;  4: fn = 6'h26;
      5: fn = 6'h27;  6: fn = 6'h2A;  7: fn = 6'h00;  8: fn = 6'h02;  9: fn = 6'h08;
      10: op = 6'h08; 11: op = 6'h0C; 12: op = 6'h0D; 13: op = 6'h0E; 14: op = 6'h0F;
      15: op = 6'h23; 16: op = 6'h2B; 17: op = 6'h04; 18: op = 6'h05;
      19: op = r[0] ? 6'h03 : 6'h02;
      20: op = r[1] ? 6'h3F : 6'h01;
      default: fn = 6'h01;
    endcase
    if (sel <= 9 || sel == 21) r = {6'h00, r[25:6], fn};
    else r[31:26] = op;
    if ($urandom_range(0, 7) == 0) r[20:16] = 5'd0;
    if ($urandom_range(0, 7) == 0) r[15:11] = 5'd0;
    return r;
  endfunction

  task automatic check_cycle(input int k, input int len, input info_t d, input logic [31:0] ins, input logic z3);
    logic [31:0] src;
    bit          last, halt_bad, wr;
    logic [4:0]  ewa;
    logic [1:0]  epcs;
    src      = (k == 1) ? prev_ir : ins;
    last     = (k == len);
    halt_bad = TRAP && (d.kind == K_BAD);
    wr       = (d.kind == K_ALU) || (d.kind == K_LW) || (d.kind == K_JAL);
    ewa      = (d.kind == K_JAL) ? 5'd31 : (d.rtype ? ins[15:11] : ins[20:16]);
    epcs     = 2'b00;
    if (last && !halt_bad) begin
      case (d.kind)
        K_BR:  epcs = ((d.beq && z3) || (!d.beq && !z3)) ? 2'b10 : 2'b00;
        K_J:   epcs = 2'b11;
        K_JR:  epcs = 2'b01;
        K_JAL: epcs = 2'b11;
        default: epcs = 2'b00;
      endcase
    end
    chk("pc_we",   32'(pc_we),   32'(last && !halt_bad));
    chk("rf_we",   32'(rf_we),   32'(last && wr && (ewa != 5'd0)));
    chk("mem_we",  32'(mem_we),  32'(last && (d.kind == K_SW)));
    chk("pc_s",    32'(pc_s),    32'(epcs));
    chk("illegal", 32'(illegal), 32'(exp_ill));
    chk("rs",      32'(rs),       32'(src[25:21]));
    chk("rt",      32'(rt),       32'(src[20:16]));
    chk("imm_data", 32'(imm_data), 32'(src[15:0]));
    chk("address", 32'(address),  32'(src[25:0]));
    if (k >= 2) begin
      if (wr) begin
        chk("wa",     32'(wa),     32'(ewa));
        chk("wd_sel", 32'(wd_sel), 32'(d.wd));
      end
      if (d.chk_alu) begin
        chk("alu_op",    32'(alu_op),    32'(d.alu));
        chk("alu_src_b", 32'(alu_src_b), 32'(d.src_b));
      end
      if (d.chk_sext) chk("imm_sext", 32'(imm_sext), 32'(d.sext));
    end
    if (pc_we === 1'b1 && first_pcwe_k == 0) begin
      first_pcwe_k = k;
      cap_wa = wa; cap_rf = rf_we; cap_wd = wd_sel; cap_pcs = pc_s;
      cap_alu = alu_op; cap_imm = imm_data; cap_addr = address;
    end
    if (mem_we === 1'b1 && first_mem_k == 0) first_mem_k = k;
  endtask

  // Entered and left just after a rising edge; cycle k=1 is the fetch cycle of ins.
  task automatic run_instr(input logic [31:0] ins, input int zmode, input int stop_k);
    info_t d;
    int    len;
    logic  z3;
    d = decode(ins);
    len = ins_len(d);
    z3 = 1'b0;
    first_pcwe_k = 0;
    first_mem_k = 0;
    for (int k = 1; k <= len; k++) begin
      inst_code = (k == 1) ? ins : $urandom();
      zero = (zmode == 2) ? 1'($urandom_range(0, 1)) : 1'(zmode);
      if (k == 3) z3 = zero;
      @(negedge clk);
      check_cycle(k, len, d, ins, z3);
      @(posedge clk);
      #1;
      if (k == 3 && d.kind == K_BAD) exp_ill = 1'b1;
      if (stop_k == k) return;
    end
    prev_ir = ins;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    #1;
    chk("rst_pc_we",  32'(pc_we),    32'd0);
    chk("rst_rf_we",  32'(rf_we),    32'd0);
    chk("rst_mem_we", 32'(mem_we),   32'd0);
    chk("rst_pc_s",   32'(pc_s),     32'd0);
    chk("rst_illegal", 32'(illegal), 32'd0);
    chk("rst_ir",     32'(address),  32'd0);
    @(posedge clk);
    #1;
    chk("rst_hold_mem_we", 32'(mem_we), 32'd0);
    chk("rst_hold_pc_we",  32'(pc_we),  32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    prev_ir = 32'h0;
    exp_ill = 1'b0;
  endtask

  initial begin
    #2;
    do_reset();

    run_instr(32'h00221820, 2, 0);
    chk("t1_len", 32'(first_pcwe_k), 32'd4);
    chk("t1_rf_we", 32'(cap_rf), 32'd1);
    chk("t1_wa", 32'(cap_wa), 32'd3);
    chk("t1_alu_op", 32'(cap_alu), 32'd0);
    chk("t1_pc_s", 32'(cap_pcs), 32'd0);

    run_instr(32'h1022FFFF, 1, 0);
    chk("t2_len", 32'(first_pcwe_k), 32'd3);
    chk("t2_pc_s_taken", 32'(cap_pcs), 32'd2);
    chk("t2_imm", 32'(cap_imm), 32'h0000FFFF);
    run_instr(32'h1022FFFF, 0, 0);
    chk("t2_pc_s_not_taken", 32'(cap_pcs), 32'd0);

    run_instr(32'h0C000040, 2, 0);
    chk("t3_len", 32'(first_pcwe_k), 32'd4);
    chk("t3_rf_we", 32'(cap_rf), 32'd1);
    chk("t3_wa", 32'(cap_wa), 32'd31);
    chk("t3_wd_sel", 32'(cap_wd), 32'd2);
    chk("t3_pc_s", 32'(cap_pcs), 32'd3);
    chk("t3_address", 32'(cap_addr), 32'h40);

    run_instr(32'hAC220010, 2, 0);
    chk("t4_sw_mem_k", 32'(first_mem_k), 32'd6);
    chk("t4_sw_len", 32'(first_pcwe_k), 32'd6);
    run_instr(32'h8C230010, 2, 0);
    chk("t4_lw_len", 32'(first_pcwe_k), 32'd7);
    chk("t4_lw_wd_sel", 32'(cap_wd), 32'd1);
    chk("t4_lw_rf_we", 32'(cap_rf), 32'd1);

`ifdef ILLEGAL_TRAP_EN
    run_instr(32'hFC000000, 2, 0);
    chk("t5_trap_no_pc_we", 32'(first_pcwe_k), 32'd0);
    for (int n = 0; n < 20; n++) begin
      inst_code = $urandom();
      @(negedge clk);
      chk("halt_pc_we", 32'(pc_we), 32'd0);
      chk("halt_rf_we", 32'(rf_we), 32'd0);
      chk("halt_mem_we", 32'(mem_we), 32'd0);
      chk("halt_illegal", 32'(illegal), 32'd1);
      @(posedge clk);
      #1;
    end
    do_reset();
`else
    run_instr(32'hFC000000, 2, 0);
    chk("t5_len", 32'(first_pcwe_k), 32'd3);
    chk("t5_pc_s", 32'(cap_pcs), 32'd0);
    run_instr(32'h00221820, 2, 0);
    chk("t5_illegal_sticky", 32'(illegal), 32'd1);
    chk("t5_next_len", 32'(first_pcwe_k), 32'd4);
    run_instr(32'h00000001, 2, 0);
    chk("t5_bad_funct_len", 32'(first_pcwe_k), 32'd3);
`endif

    for (int n = 0; n < 300; n++) run_instr(rand_ins(!TRAP), 2, 0);

    run_instr(32'hAC220010, 2, 4);
    #2;
    do_reset();
    run_instr(32'hAC220010, 2, 0);
    chk("t6_restart_sw_len", 32'(first_pcwe_k), 32'd6);
    for (int n = 0; n < 20; n++) run_instr(rand_ins(1'b0), 2, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "time limit");
  end

endmodule
